// File: rtl/axis_ramp_pkt_checker_pkg.sv
// Shared types and constants for the ramp packet checker and its LFSR.
package axis_ramp_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/axis_ramp_pkt_checker_if.sv
// AXI-Stream data/handshake bundle between a ramp source and the checker.
interface axis_ramp_pkt_checker_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_ramp_pkt_checker_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; low OUT_W bits of the state are exposed.
module axis_lfsr16
    import axis_ramp_chk_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_SEED,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] rnd
);
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    assign rnd = lfsr[OUT_W-1:0];
endmodule

// File: rtl/axis_ramp_pkt_checker.sv
// AXI-Stream sink that checks each packet against a per-packet ramp and its length,
// counting good packets, data errors and length errors, with optional LFSR backpressure.
//
// state | meaning
// IDLE  | not accepting; waits for cfg_en
// CHECK | accepting and comparing every word against the ramp
// DRAIN | packet overran its length; discard words up to tlast
module axis_ramp_pkt_checker
    import axis_ramp_chk_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_en,
    input  logic [15:0]          cfg_pkt_len,
    input  logic [DWIDTH-1:0]    cfg_ramp_start,
    input  logic [DWIDTH-1:0]    cfg_ramp_inc,
    input  logic                 cfg_throttle,
    input  logic                 clear,
    axis_ramp_pkt_checker_if.slave axis,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [CNT_W-1:0]     data_err_count,
    output logic [CNT_W-1:0]     len_err_count,
    output logic                 err_pulse,
    output logic                 err_sticky
);
    state_t            state;
    logic [15:0]       idx;
    logic [15:0]       len_r;
    logic [DWIDTH-1:0] exp_r;
    logic [DWIDTH-1:0] inc_r;
    logic              bad_r;
    logic              lfsr_bit;

    logic              xfer;
    logic              first;
    logic [15:0]       eff_len;
    logic [15:0]       last_idx;
    logic [DWIDTH-1:0] exp_word;
    logic              data_bad;
    logic              early;
    logic              missing;
    logic              chk_ev;
    logic              bad_prev;
    logic              derr_ev;
    logic              lerr_ev;
    logic              good_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    axis_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (1)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .rnd   (lfsr_bit)
    );

    assign axis.tready = (state != IDLE) & (~cfg_throttle | lfsr_bit);
    assign xfer        = axis.tvalid & axis.tready;

    // Word 0 uses live config; later words use values latched at word 0.
    assign first    = (idx == 16'd0);
    assign eff_len  = first ? cfg_pkt_len : len_r;
    assign last_idx = eff_len - 16'd1;
    assign exp_word = first ? cfg_ramp_start : exp_r;
    assign data_bad = (axis.tdata != exp_word);
    assign early    = (eff_len != 16'd0) & axis.tlast & (idx < last_idx);
    assign missing  = (eff_len != 16'd0) & ~axis.tlast & (idx == last_idx);

    assign chk_ev   = xfer & (state == CHECK);
    assign bad_prev = ~first & bad_r;
    assign derr_ev  = chk_ev & data_bad;
    assign lerr_ev  = chk_ev & (early | missing);
    assign good_ev  = chk_ev & axis.tlast & ~bad_prev & ~data_bad & ~early;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= 16'd0;
            len_r          <= 16'd0;
            exp_r          <= '0;
            inc_r          <= '0;
            bad_r          <= 1'b0;
            pkt_count      <= '0;
            data_err_count <= '0;
            len_err_count  <= '0;
            err_pulse      <= 1'b0;
            err_sticky     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_en) state <= CHECK;
                end
                CHECK: begin
                    if (chk_ev) begin
                        if (first) begin
                            len_r <= cfg_pkt_len;
                            inc_r <= cfg_ramp_inc;
                        end
                        if (axis.tlast) begin
                            idx   <= 16'd0;
                            bad_r <= 1'b0;
                            state <= cfg_en ? CHECK : IDLE;
                        end else if (missing) begin
                            idx   <= 16'd0;
                            bad_r <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            idx   <= (idx == 16'hFFFF) ? idx : idx + 16'd1;
                            exp_r <= exp_word + (first ? cfg_ramp_inc : inc_r);
                            bad_r <= bad_prev | data_bad;
                        end
                    end else if (first && !cfg_en) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (xfer && axis.tlast) state <= cfg_en ? CHECK : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (clear) begin
                pkt_count      <= '0;
                data_err_count <= '0;
                len_err_count  <= '0;
                err_pulse      <= 1'b0;
                err_sticky     <= 1'b0;
            end else begin
                pkt_count      <= sat_inc(pkt_count, good_ev);
                data_err_count <= sat_inc(data_err_count, derr_ev);
                len_err_count  <= sat_inc(len_err_count, lerr_ev);
                err_pulse      <= derr_ev | lerr_ev;
                err_sticky     <= err_sticky | derr_ev | lerr_ev;
            end
        end
    end
endmodule

// File: tb/tb_axis_ramp_pkt_checker.sv
// Scoreboard bench for axis_ramp_pkt_checker: each driven word queues its expected
// post-transfer status; a negedge monitor pops and compares after each accepted word.
module tb_axis_ramp_pkt_checker;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_en;
    logic [15:0] cfg_pkt_len;
    logic [31:0] cfg_ramp_start;
    logic [31:0] cfg_ramp_inc;
    logic        cfg_throttle;
    logic        clear;
    logic [15:0] pkt_count;
    logic [15:0] data_err_count;
    logic [15:0] len_err_count;
    logic        err_pulse;
    logic        err_sticky;

    axis_ramp_pkt_checker_if #(.DWIDTH(32)) bus ();

    axis_ramp_pkt_checker #(.DWIDTH(32), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_en         (cfg_en),
        .cfg_pkt_len    (cfg_pkt_len),
        .cfg_ramp_start (cfg_ramp_start),
        .cfg_ramp_inc   (cfg_ramp_inc),
        .cfg_throttle   (cfg_throttle),
        .clear          (clear),
        .axis           (bus),
        .pkt_count      (pkt_count),
        .data_err_count (data_err_count),
        .len_err_count  (len_err_count),
        .err_pulse      (err_pulse),
        .err_sticky     (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        sticky;
        logic [15:0] pkt;
        logic [15:0] derr;
        logic [15:0] lerr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    logic        pending = 1'b0;
    logic        thr_chk = 1'b0;
    logic [15:0] lfsr_m;
    logic [15:0] m_pkt, m_derr, m_lerr;
    logic        m_sticky;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference throttle sequence: x^16+x^14+x^13+x^11, shifting right
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    always @(negedge clk) begin
        if (pending) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: transfer seen with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                if (err_pulse !== mon_e.err || err_sticky !== mon_e.sticky ||
                    pkt_count !== mon_e.pkt || data_err_count !== mon_e.derr ||
                    len_err_count !== mon_e.lerr) begin
                    n_fail++;
                    $display("FAIL xfer_status @%0t: got pulse=%b sticky=%b pkt=%0d derr=%0d lerr=%0d, want pulse=%b sticky=%b pkt=%0d derr=%0d lerr=%0d",
                             $time, err_pulse, err_sticky, pkt_count, data_err_count, len_err_count,
                             mon_e.err, mon_e.sticky, mon_e.pkt, mon_e.derr, mon_e.lerr);
                end
            end
        end
        pending = bus.tvalid & bus.tready & ~reset;
        if (thr_chk) begin
            n_cmp++;
            if (bus.tready !== lfsr_m[0]) begin
                n_fail++;
                $display("FAIL tready_lfsr @%0t: got %b want %b", $time, bus.tready, lfsr_m[0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic de,
                             input logic le, input logic good, input logic clr = 1'b0);
        exp_t e;
        int   cyc;
        logic acc;
        if (clr) begin
            m_pkt = 0; m_derr = 0; m_lerr = 0; m_sticky = 1'b0;
            e.err = 1'b0;
        end else begin
            m_derr = m_derr + 16'(de);
            m_lerr = m_lerr + 16'(le);
            if (good) m_pkt = m_pkt + 16'd1;
            if (de | le) m_sticky = 1'b1;
            e.err = de | le;
        end
        e.sticky = m_sticky; e.pkt = m_pkt; e.derr = m_derr; e.lerr = m_lerr;
        sb.push_back(e);
        bus.tdata = d; bus.tlast = l; bus.tvalid = 1'b1; clear = clr;
        cyc = 0; acc = 1'b0;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            acc = bus.tready;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.tvalid = 1'b0; clear = 1'b0;
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: word %0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic send_ramp(input logic [31:0] start, input logic [31:0] inc, input int n);
        for (int k = 0; k < n; k++)
            send_word(start + inc * k, k == n - 1, 1'b0, 1'b0, k == n - 1);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        reset = 1'b1; cfg_en = 1'b0; cfg_pkt_len = 16'd8; cfg_ramp_start = 0; cfg_ramp_inc = 1;
        cfg_throttle = 1'b0; clear = 1'b0;
        bus.tdata = 0; bus.tvalid = 1'b0; bus.tlast = 1'b0;
        m_pkt = 0; m_derr = 0; m_lerr = 0; m_sticky = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", {31'd0, bus.tready}, 0);
        chk("rst_counts", {pkt_count, data_err_count | len_err_count}, 0);
        chk("rst_flags", {30'd0, err_pulse, err_sticky}, 0);
        reset = 1'b0; cfg_en = 1'b1;
        @(negedge clk);
        chk("tready_idle", {31'd0, bus.tready}, 0);
        @(negedge clk);
        chk("tready_on", {31'd0, bus.tready}, 1);
        @(posedge clk);
        #1;

        // Four back-to-back 0..7 packets, no bubbles
        t0 = cyc_cnt;
        for (int p = 0; p < 4; p++) send_ramp(0, 1, 8);
        chk("no_bubble_cycles", cyc_cnt - t0, 32);
        chk("pkt_after_4", {16'd0, pkt_count}, 4);

        // Wrap-around ramp
        cfg_ramp_start = 32'hFFFF_FFFE; cfg_pkt_len = 4;
        send_word(32'hFFFF_FFFE, 0, 0, 0, 0);
        send_word(32'hFFFF_FFFF, 0, 0, 0, 0);
        send_word(32'h0000_0000, 0, 0, 0, 0);
        send_word(32'h0000_0001, 1, 0, 0, 1);
        // start=100 inc=3
        cfg_ramp_start = 100; cfg_ramp_inc = 3;
        send_word(100, 0, 0, 0, 0); send_word(103, 0, 0, 0, 0);
        send_word(106, 0, 0, 0, 0); send_word(109, 1, 0, 0, 1);
        // len=0: no length check
        cfg_pkt_len = 0; cfg_ramp_start = 7; cfg_ramp_inc = 5;
        send_word(7, 0, 0, 0, 0); send_word(12, 0, 0, 0, 0); send_word(17, 1, 0, 0, 1);
        // len=1 single word
        cfg_pkt_len = 1; cfg_ramp_start = 42;
        send_word(42, 1, 0, 0, 1);

        // Data error on word 3, then clean packet
        cfg_pkt_len = 8; cfg_ramp_start = 0; cfg_ramp_inc = 1;
        for (int k = 0; k < 8; k++)
            send_word(k == 3 ? 32'hDEAD : k, k == 7, k == 3, 0, 0);
        send_ramp(0, 1, 8);

        // Early tlast on word 5, next word is word 0
        for (int k = 0; k < 6; k++) send_word(k, k == 5, 0, k == 5, 0);
        send_ramp(0, 1, 8);

        // 10 words with len=8: length error on word 7, words 8-9 drained unchecked
        for (int k = 0; k < 8; k++) send_word(k, 0, 0, k == 7, 0);
        send_word(32'h5555_0000, 0, 0, 0, 0);
        send_word(32'h5555_0001, 1, 0, 0, 0);
        send_ramp(0, 1, 8);

        // Bad data and early tlast on the same word
        send_word(0, 0, 0, 0, 0); send_word(1, 0, 0, 0, 0);
        send_word(32'h99, 1, 1, 1, 0);
        gap(2);
        chk("pulse_single", {31'd0, err_pulse}, 0);

        // Throttled, random gaps, config scrambled after word 0 to exercise latching
        cfg_throttle = 1'b1; thr_chk = 1'b1;
        for (int p = 0; p < 100; p++) begin
            logic [31:0] st;
            st = p * 7;
            cfg_pkt_len = 4; cfg_ramp_start = st; cfg_ramp_inc = 3;
            for (int k = 0; k < 4; k++) begin
                gap($urandom_range(0, 2));
                send_word(st + 3 * k, k == 3, 0, 0, k == 3);
                if (k == 0) begin
                    cfg_pkt_len = 2; cfg_ramp_start = 32'hFFFF_0000; cfg_ramp_inc = 0;
                end
            end
        end
        thr_chk = 1'b0; cfg_throttle = 1'b0;
        gap(2);
        chk("pkt_total", {16'd0, pkt_count}, 111);
        chk("derr_total", {16'd0, data_err_count}, 2);
        chk("lerr_total", {16'd0, len_err_count}, 3);
        chk("sticky_set", {31'd0, err_sticky}, 1);

        // Reset mid-packet
        cfg_pkt_len = 8; cfg_ramp_start = 0; cfg_ramp_inc = 1;
        send_word(0, 0, 0, 0, 0); send_word(1, 0, 0, 0, 0); send_word(2, 0, 0, 0, 0);
        gap(2);
        reset = 1'b1;
        #1;
        m_pkt = 0; m_derr = 0; m_lerr = 0; m_sticky = 1'b0;
        chk("midrst_tready", {31'd0, bus.tready}, 0);
        chk("midrst_counts", {pkt_count, data_err_count | len_err_count}, 0);
        chk("midrst_flags", {30'd0, err_pulse, err_sticky}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_ramp(0, 1, 8);
        chk("pkt_after_rst", {16'd0, pkt_count}, 1);

        // Clear in the same cycle as an erroring transfer
        cfg_pkt_len = 1; cfg_ramp_start = 5;
        send_word(32'hBAD, 1, 1, 0, 0, 1'b1);
        send_word(5, 1, 0, 0, 1);
        gap(3);
        chk("sb_drained", sb.size(), 0);
        chk("final_pkt", {16'd0, pkt_count}, 1);
        chk("final_errs", {data_err_count, len_err_count}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axis_ramp_pkt_checker.md
# axis_ramp_pkt_checker

- Synthesizable AXI-Stream sink. It accepts packets, checks each one against the ramp pattern the test stimulus pushes (word k = start + k·inc, ramp restarts every packet) and checks packet length.
- Counts good packets, data errors and length errors, and can apply pseudo-random backpressure.
- Sits at the receive end of loopback and DUT-bring-up paths, both in simulation and on hardware.

## Interface
Parameters:
- DWIDTH, 32, data width of the stream and the ramp arithmetic
- CNT_W, 16, width of the status counters

Ports:
- clk  in  1  single clock; all logic synchronous to the rising edge
- reset  in  1  asynchronous, active-high
- cfg_en  in  1  checker enable
- cfg_pkt_len  in  16  expected words per packet; 0 disables length checking
- cfg_ramp_start  in  DWIDTH  value of word 0
- cfg_ramp_inc  in  DWIDTH  increment per word
- cfg_throttle  in  1  enables LFSR-gated tready
- clear  in  1  synchronous clear of counters and err_sticky
- i_tdata  in  DWIDTH  stream data
- i_tvalid  in  1  stream valid
- i_tlast  in  1  end of packet
- i_tready  out  1  stream ready
- pkt_count  out  CNT_W  packets completed with no error
- data_err_count  out  CNT_W  mismatching words
- len_err_count  out  CNT_W  packets with wrong length
- err_pulse  out  1  one-cycle flag for any error
- err_sticky  out  1  latched OR of all errors since reset/clear

## Operation
- A transfer is a cycle with i_tvalid & i_tready.
- States:
  - IDLE: i_tready=0. Goes to CHECK when cfg_en=1.
  - CHECK: i_tready=1 (gated by throttle). Compares every word.
  - DRAIN: i_tready=1 (gated). Discards words until i_tlast, then returns to CHECK, or to IDLE if cfg_en=0.
- Config is captured on the first word of each packet: start, inc and len are latched into working registers.
- Word 0 is compared against cfg_ramp_start directly. Words 1.. are compared against the latched registers.
- Expected value: expect = start on word 0, then expect += inc per transfer. Arithmetic is modulo 2^DWIDTH; wrap-around is legal, not an error.
- Word index counter is 16 bits and saturates.
- Data mismatch: data_err_count +1 per bad word. The packet is marked bad and checking continues.
- Early tlast (index < len-1, len≠0): len_err_count +1, packet ends, next word is word 0.
- Missing tlast at index len-1: len_err_count +1, go to DRAIN. Words in DRAIN are not data-checked.
- Packet ending in CHECK with no error: pkt_count +1. A bad packet never increments pkt_count.
- Mismatch and length error on the same word: both counters increment, and err_pulse is a single pulse.
- cfg_en deasserted mid-packet takes effect only after the current packet's tlast. The block never truncates a packet.
- Counters saturate at all-ones.
- clear has priority over same-cycle increments: counters go to 0 and that cycle's events are lost.
- Throttle: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advances every cycle. i_tready = active & (~cfg_throttle | lfsr[0]).
- i_tready never depends on i_tvalid.

## Timing
- Reset values:
  - state = IDLE
  - i_tready = 0
  - all counters = 0
  - err_pulse = 0
  - err_sticky = 0
  - LFSR = 16'hACE1
- Reset asserted mid-packet aborts it with no counter update. After release the next word is treated as word 0.
- i_tready is asserted the cycle after cfg_en is sampled high in IDLE.
- Counters, err_pulse and err_sticky update on the clock edge that completes the offending or final transfer. They are visible the next cycle, so latency is 1.
- err_pulse is high exactly one cycle per erroring transfer.
- With cfg_throttle=0 the block sustains one word per cycle, with no bubble between packets.

## Structure
- Package axis_ramp_chk_pkg holds:
  - the state enum (IDLE, CHECK, DRAIN)
  - LFSR_SEED = 16'hACE1
  - the LFSR tap mask
- Sub-module axis_lfsr16: free-running LFSR with async reset and a seed parameter. Reused by the matching generator.
- Counter saturation is a local function; no sub-module.

## Test plan
- Packets: 4 packets, len=8, start=0, inc=1, no throttle -> pkt_count=4, both error counts 0, i_tready high for 32 consecutive cycles.
- Wrap: start=32'hFFFF_FFFE, inc=1, len=4 -> words FFFE, FFFF, 0, 1 accepted; pkt_count=1, no error.
- Data error: word 3 corrupted in a len=8 packet -> data_err_count=1, err_pulse one cycle after word 3, pkt_count=0, err_sticky=1; next clean packet -> pkt_count=1.
- Length errors:
  - tlast on word 5 with len=8 -> len_err_count=1; next word checked as word 0.
  - 10-word packet with len=8 -> len_err_count=1; DRAIN until tlast; no data errors counted for words 8–9.
- Throttle with random i_tvalid gaps, 100 packets -> pkt_count=100, zero errors; i_tready follows lfsr[0].
- Control: reset asserted mid-packet -> all outputs at reset values immediately, then the next packet is checked correctly. clear together with a pending error -> counters read 0.
